// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and constants for the cell configuration path
// Contents: FSM state enum, cell RAM width, cell RAM bit positions (shared with the cell array).
package cfg_pkg;

  localparam int CELL_RAM_W = 4;

  // Bit positions inside the 4-bit cell RAM word {STATE, NULL, RAM1, RAM0}
  localparam int RAM0      = 0;
  localparam int RAM1      = 1;
  localparam int NULL_BIT  = 2;
  localparam int STATE_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/nibble_unpacker.sv
// rtl/nibble_unpacker.sv - genome word register with 4-bit nibble select
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture data_i into the word register this cycle
//   data_i     : incoming packed word
//   sel_i      : nibble index to present on nibble_o
//   nibble_o   : selected nibble (taken from data_i while loading so the
//                first nibble is available in the capture cycle)
module nibble_unpacker
  import cfg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [NIB_W-1:0]      sel_i,
  output logic [CELL_RAM_W-1:0] nibble_o
);

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= data_i;
    end
  end

  assign src      = load_i ? data_i : word_q;
  assign nibble_o = src[sel_i*CELL_RAM_W +: CELL_RAM_W];

endmodule

// File: rtl/cell_config_writer.sv
// rtl/cell_config_writer.sv - unpacks genome words into per-cell RAM writes with one-hot strobes
// Optional feature macro: CFG_CHECKSUM_EN (adds cfg_checksum output).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, abort     : begin a full array load / cancel the current load
//   in_data/in_valid/in_ready : packed genome word stream
//   cell_ram         : broadcast RAM-set value {STATE, NULL, RAM1, RAM0}
//   cell_write_en    : one-hot per-cell write strobe
//   cell_index       : cell currently being written
//   busy, done       : load in progress / one-cycle completion pulse
//   cfg_checksum     : XOR of all strobed nibbles (CFG_CHECKSUM_EN only)
module cell_config_writer
  import cfg_pkg::*;
#(
  parameter int N_CELLS = 64,
  parameter int DATA_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CELL_RAM_W-1:0]        cell_ram,
  output logic [N_CELLS-1:0]           cell_write_en,
  output logic [$clog2(N_CELLS)-1:0]   cell_index,
  output logic                         busy,
`ifdef CFG_CHECKSUM_EN
  output logic [CELL_RAM_W-1:0]        cfg_checksum,
`endif
  output logic                         done
);

  localparam int CPW   = DATA_W / CELL_RAM_W;
  localparam int IDX_W = $clog2(N_CELLS);
  localparam int NIB_W = (CPW > 1) ? $clog2(CPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(CPW - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NIB_W-1:0]        nib_q, nib_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CELL_RAM_W-1:0]   cell_ram_q, cell_ram_d;
  logic [N_CELLS-1:0]      we_q, we_d;
  logic                    word_load;
  logic [CELL_RAM_W-1:0]   nibble;

  nibble_unpacker #(
    .DATA_W (DATA_W),
    .NIB_W  (NIB_W)
  ) u_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (word_load),
    .data_i   (in_data),
    .sel_i    (nib_d),
    .nibble_o (nibble)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nib_d     = nib_q;
    word_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
        end
      end
      ST_FETCH: begin
        if (in_valid && in_ready_q) begin
          word_load = 1'b1;
          nib_d     = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        if (idx_q == LAST_IDX) begin
          // Unused upper nibbles of a partial last word are simply dropped.
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
          if (nib_q == LAST_NIB) begin
            state_d = ST_FETCH;
          end else begin
            nib_d   = nib_q + 1'b1;
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // abort wins over start and over a same-cycle word handshake
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      word_load = 1'b0;
    end

    // Outputs are decoded from the next state so they register in step with it.
    in_ready_d = (state_d == ST_FETCH);
    busy_d     = (state_d == ST_FETCH) || (state_d == ST_SETUP) || (state_d == ST_STROBE);
    done_d     = (state_d == ST_DONE);
    we_d       = '0;
    if (state_d == ST_STROBE) we_d[idx_q] = 1'b1;
    // cell_ram only changes on entry to SETUP, so it is stable a full cycle before the strobe.
    cell_ram_d = (state_d == ST_SETUP) ? nibble : cell_ram_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      nib_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cell_ram_q <= '0;
      we_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      nib_q      <= nib_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cell_ram_q <= cell_ram_d;
      we_q       <= we_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cell_ram      = cell_ram_q;
  assign cell_write_en = we_q;
  assign cell_index    = idx_q;

`ifdef CFG_CHECKSUM_EN
  logic [CELL_RAM_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      csum_q <= '0;
    end else if (state_q == ST_STROBE) begin
      csum_q <= csum_q ^ cell_ram_q;
    end
  end

  assign cfg_checksum = csum_q;
`endif

endmodule

// File: doc/cell_config_writer.md
Name: cell_config_writer

Overview:
- Configuration loader for the logic-block array: the writing end of the cell RAM-set / write-enable interface.
- Accepts packed genome words from Linux over a valid/ready stream and unpacks them into 4-bit cell configurations.
- Drives a broadcast cell_ram bus plus one-hot per-cell write-enable pulses, cell 0 to cell N_CELLS-1.
- Sits between the Linux-side bridge and the cell array; one instance per array.

Parameters:
- N_CELLS, 64, number of logic blocks configured per load.
- DATA_W, 32, input word width; must be a multiple of 4; CPW = DATA_W/4 cells per word.

Ports:
- clk  input  1  cell/system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a full array load.
- abort  input  1  stop the current load; return to IDLE.
- in_data  input  DATA_W  packed genome word; nibble k = in_data[4k+3:4k].
- in_valid  input  1  in_data valid.
- in_ready  output  1  writer will accept in_data this cycle.
- cell_ram  output  4  broadcast RAM-set value {STATE, NULL, RAM1, RAM0}.
- cell_write_en  output  N_CELLS  one-hot write strobe; cells latch cell_ram on its rising edge.
- cell_index  output  clog2(N_CELLS)  index of the cell currently being written.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the last cell strobe.

Behaviour:
- Reset (async, rst_n low): in_ready=0, cell_ram=0, cell_write_en=0, cell_index=0, busy=0, done=0; FSM=IDLE. Any write_en in flight drops immediately; a partially written array is left as-is.
- All outputs are registered; no combinational path from inputs to cell_write_en or cell_ram.
- FSM states: IDLE, FETCH, SETUP, STROBE, DONE.
- IDLE: start=1 -> FETCH, busy=1, cell_index=0. start while busy is ignored.
- FETCH: in_ready=1. On in_valid&in_ready, capture word, set nibble=0 -> SETUP. While in_valid=0, wait indefinitely; busy stays 1.
- SETUP: cell_ram=captured nibble; cell_write_en=0 -> STROBE.
- STROBE: cell_write_en[cell_index]=1 only; cell_ram held unchanged (setup ≥1 clk before the rising edge, hold through the strobe).
- After STROBE, choose the next state:
  - cell_index==N_CELLS-1 -> DONE.
  - else if nibble==CPW-1 -> FETCH.
  - else nibble+1 -> SETUP.
- cell_index increments on leaving STROBE, except on the last cell.
- Leaving STROBE always clears cell_write_en the next cycle. cell_ram may change in that same cycle; this is safe because the cells are rising-edge triggered.
- DONE: done=1 for exactly one cycle, busy=0, cell_index=0 -> IDLE.
- Throughput: 2 clk per cell plus 1 clk per word fetch when in_valid is already high. Default full load = 8×(1+16)=136 clk from first FETCH to DONE.
- Partial last word (N_CELLS not a multiple of CPW): unused upper nibbles are discarded; no extra word is consumed.
- abort (any non-IDLE state): next cycle FSM=IDLE, write_en=0, in_ready=0, busy=0; done is not pulsed. abort has priority over start and in_valid in the same cycle.
- cell_ram bit 2 (NULL) is passed through unchanged; the writer does no validation of genome content.

Optional Feature:
- Macro CFG_CHECKSUM_EN.
- Defined:
  - Extra output cfg_checksum[3:0] = XOR of every nibble strobed in the current load.
  - Cleared on start acceptance and on reset.
  - Valid and stable from the done pulse until the next start.
- Undefined: port absent; no checksum logic.

Decomposition:
- Shared package cfg_pkg:
  - FSM state enum.
  - CELL_RAM_W=4.
  - Bit-position constants RAM0=0, RAM1=1, NULL_BIT=2, STATE_BIT=3 (shared with the cell array).
- Optional sub-module nibble_unpacker: word register plus nibble select, taking DATA_W and nibble index. The FSM and one-hot decode stay in the top.

Test Plan:
- Reset mid-STROBE (cell 5, write_en[5]=1) by pulling rst_n low -> write_en=0, busy=0, cell_ram=0 asynchronously; after release the FSM is IDLE and in_ready=0.
- start, then 8 words 0x76543210 each with valid always high -> cell k receives nibble k mod 8; write_en strobes one-hot in order 0..63; each strobe is preceded by one cycle of stable cell_ram; done pulses at cycle 136; busy falls with done.
- in_valid held low for 10 clk at the word-3 fetch -> in_ready stays high; no strobes occur; busy=1; resume produces cells 24..31 correctly.
- N_CELLS=10, DATA_W=32, words 0xFFFFFFFF, 0xAAAAAAAB -> cells 0–7=0xF, cell 8=0xB, cell 9=0xA; only 2 words consumed; done after the last strobe.
- abort asserted in the same cycle as in_valid during FETCH of word 2 -> word not accepted, no done pulse, IDLE next cycle; a following start restarts at cell 0.
- With CFG_CHECKSUM_EN, 8 words of 0x00000001 -> cfg_checksum=0x0 (eight 1s XOR); one word changed to 0x00000003 -> cfg_checksum=0x2.
